// File: rtl/nios_sys_mem_test_master.sv
// nios_sys_mem_test_master: Avalon-MM fill/check initiator for the on-chip RAM.
// Writes seed+i over a word range and/or reads it back, counting and logging mismatches.
module nios_sys_mem_test_master #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              do_fill,
    input  logic              do_check,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] err_addr,
    output logic [31:0]       err_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W:0]         idx_q, idx_d, len_q;
    logic [ADDR_W-1:0]       base_q;
    logic [31:0]             seed_q;
    logic                    check_q, done_q, last, mismatch;
    logic [READ_LATENCY-1:0] vld_q;
    logic [ADDR_W-1:0]       pa_q [READ_LATENCY];
    logic [31:0]             pe_q [READ_LATENCY];

    // Bus strobes decode straight from state so an async reset drops them at once.
    assign mem_chipselect = (state_q == WRITE) || (state_q == READ);
    assign mem_write      = state_q == WRITE;
    assign mem_address    = base_q + idx_q[ADDR_W-1:0];
    assign mem_writedata  = seed_q + 32'(idx_q);
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign busy           = state_q != IDLE;
    assign done           = done_q;
    assign last           = idx_q == len_q - (ADDR_W+1)'(1);
    assign mismatch       = vld_q[READ_LATENCY-1] && (mem_readdata != pe_q[READ_LATENCY-1]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (start)
                    state_d = (length == '0 || !(do_fill || do_check)) ? FINISH :
                              do_fill ? WRITE : READ;
            end
            WRITE: begin
                idx_d = last ? '0 : idx_q + (ADDR_W+1)'(1);
                if (last) state_d = check_q ? READ : FINISH;
            end
            READ: begin
                idx_d = idx_q + (ADDR_W+1)'(1);
                if (last) state_d = DRAIN;
            end
            // Leave once nothing but the oldest stage (compared this cycle) is in flight.
            DRAIN:   state_d = ~|(vld_q << 1) ? FINISH : DRAIN;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            base_q    <= '0;
            seed_q    <= '0;
            check_q   <= 1'b0;
            done_q    <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
            err_data  <= '0;
            vld_q     <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pa_q[k] <= '0;
                pe_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= state_q == FINISH;
            if (state_q == IDLE && start) begin
                len_q     <= length;
                base_q    <= base_addr;
                seed_q    <= seed;
                check_q   <= do_check;
                error     <= 1'b0;
                err_count <= '0;
                err_addr  <= '0;
                err_data  <= '0;
            end else if (mismatch) begin
                error     <= 1'b1;
                err_count <= err_count + (ADDR_W+1)'(1);
                if (!error) begin
                    err_addr <= pa_q[READ_LATENCY-1];
                    err_data <= mem_readdata;
                end
            end
            // Expected word equals the write pattern at the same index.
            vld_q[0] <= state_q == READ;
            pa_q[0]  <= mem_address;
            pe_q[0]  <= mem_writedata;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                pa_q[k]  <= pa_q[k-1];
                pe_q[k]  <= pe_q[k-1];
            end
        end
    end
endmodule

// File: tb/tb_nios_sys_mem_test_master.sv
// tb_nios_sys_mem_test_master: drives fill/check operations against a RAM slave and
// compares bus traffic, timing and error reporting with an array-based reference model.
module tb_nios_sys_mem_test_master;
    localparam int AW = 10;
    localparam int RL = 1;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset, start, do_fill, do_check;
    logic [AW-1:0] base_addr;
    logic [AW:0] length;
    logic [31:0] seed;
    logic busy, done, error;
    logic [AW:0] err_count;
    logic [AW-1:0] err_addr, mem_address;
    logic [31:0] err_data, mem_writedata, mem_readdata;
    logic [3:0] mem_byteenable;
    logic mem_chipselect, mem_write, mem_clken;

    nios_sys_mem_test_master #(.ADDR_W(AW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .start(start), .do_fill(do_fill), .do_check(do_check),
        .base_addr(base_addr), .length(length), .seed(seed), .busy(busy), .done(done),
        .error(error), .err_count(err_count), .err_addr(err_addr), .err_data(err_data),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'(i) * 32'h9E37_79B9 ^ 32'h1234_5678;
    endfunction

    // RAM slave with one-cycle read latency plus a backdoor write port.
    logic [31:0] ram [DEPTH];
    logic init_ram = 1'b1, bd_we = 1'b0;
    logic [AW-1:0] bd_a = '0;
    logic [31:0] bd_d = '0;
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = pat(i);
        end else if (bd_we) ram[bd_a] = bd_d;
        else if (mem_chipselect && mem_write) ram[mem_address] = mem_writedata;
        else if (mem_chipselect) mem_readdata <= ram[mem_address];
    end

    logic [31:0] ref_mem [DEPTH];
    int n_pass = 0, n_total = 0;

    logic [AW-1:0] exp_a[$], cap_a[$];
    logic exp_we[$], cap_we[$];
    logic [31:0] exp_d[$], cap_d[$];
    int exp_cnt, exp_done, first_cyc, last_cyc, done_cyc, busy_bad, extra;
    logic [AW-1:0] exp_eaddr;
    logic [31:0] exp_edata;

    task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_a = a; bd_d = d; ref_mem[a] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Reference: list of expected accesses, RAM contents after fill, mismatch summary.
    task automatic model_op(input logic f, input logic c, input logic [AW-1:0] b,
                            input logic [AW:0] l, input logic [31:0] sd);
        logic [AW-1:0] a;
        exp_a.delete(); exp_we.delete(); exp_d.delete();
        exp_cnt = 0; exp_eaddr = '0; exp_edata = '0;
        if (l != 0 && f)
            for (int i = 0; i < int'(l); i++) begin
                a = AW'(int'(b) + i);
                exp_a.push_back(a); exp_we.push_back(1'b1); exp_d.push_back(sd + 32'(i));
                ref_mem[a] = sd + 32'(i);
            end
        if (l != 0 && c)
            for (int i = 0; i < int'(l); i++) begin
                a = AW'(int'(b) + i);
                exp_a.push_back(a); exp_we.push_back(1'b0); exp_d.push_back('0);
                if (ref_mem[a] !== sd + 32'(i)) begin
                    if (exp_cnt == 0) begin exp_eaddr = a; exp_edata = ref_mem[a]; end
                    exp_cnt++;
                end
            end
        exp_done = exp_a.size() == 0 ? 2 : exp_a.size() + 2 + ((l != 0 && c) ? RL : 0);
    endtask

    task automatic run_op(input logic f, input logic c, input logic [AW-1:0] b,
                          input logic [AW:0] l, input logic [31:0] sd, input int glitch);
        cap_a.delete(); cap_we.delete(); cap_d.delete();
        first_cyc = -1; last_cyc = -1; done_cyc = -1; busy_bad = 0; extra = 0;
        @(negedge clk);
        start = 1'b1; do_fill = f; do_check = c; base_addr = b; length = l; seed = sd;
        for (int cyc = 1; cyc <= 3000 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (mem_chipselect) begin
                cap_a.push_back(mem_address); cap_we.push_back(mem_write);
                cap_d.push_back(mem_write ? mem_writedata : 32'h0);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (done) done_cyc = cyc;
            if (busy !== !done) busy_bad++;
            start = (cyc == glitch);
            do_fill = 1'($urandom); do_check = 1'($urandom); base_addr = AW'($urandom);
            length = (AW+1)'($urandom); seed = $urandom;
        end
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done || mem_chipselect || busy) extra++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; do_fill = 1'b0; do_check = 1'b0;
        base_addr = '0; length = '0; seed = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
        init_ram = 1'b0;
        n_total++;
        if ({busy, done, error, err_count, err_addr, err_data, mem_chipselect, mem_write,
             mem_address, mem_writedata} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b cnt=%0d ea=%h ed=%h cs=%b we=%b a=%h wd=%h want all 0",
                     busy, done, error, err_count, err_addr, err_data, mem_chipselect, mem_write,
                     mem_address, mem_writedata);
        else n_pass++;
        n_total++;
        if ({mem_byteenable, mem_clken} !== 5'b11111)
            $display("FAIL reset_consts: got be=%h clken=%b want be=f clken=1", mem_byteenable, mem_clken);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [AW-1:0] bs [3] = '{10'h000, 10'h3FE, 10'h000};
        logic [AW:0] ls [3] = '{11'd4, 11'd4, 11'd1024};
        logic [31:0] ss [3] = '{32'h100, 32'h7777_0000, 32'hFFFF_FFFE};
        for (int t = 0; t < 3; t++) begin
            model_op(1'b1, 1'b0, bs[t], ls[t], ss[t]);
            run_op(1'b1, 1'b0, bs[t], ls[t], ss[t], 0);
            n_total++;
            if (cap_a.size() !== exp_a.size())
                $display("FAIL fill%0d_count: got %0d want %0d", t, cap_a.size(), exp_a.size());
            else n_pass++;
            for (int i = 0; i < exp_a.size() && i < cap_a.size(); i++) begin
                n_total++;
                if ({cap_we[i], cap_a[i], cap_d[i]} !== {exp_we[i], exp_a[i], exp_d[i]})
                    $display("FAIL fill%0d_access%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h", t, i,
                             cap_we[i], cap_a[i], cap_d[i], exp_we[i], exp_a[i], exp_d[i]);
                else n_pass++;
            end
            n_total++;
            if ({first_cyc, last_cyc, done_cyc} !== {1, exp_a.size(), exp_done})
                $display("FAIL fill%0d_timing: got first=%0d last=%0d done=%0d want 1 %0d %0d", t,
                         first_cyc, last_cyc, done_cyc, exp_a.size(), exp_done);
            else n_pass++;
            n_total++;
            if ({busy_bad, extra} !== {32'd0, 32'd0})
                $display("FAIL fill%0d_busy: got busy_bad=%0d extra=%0d want 0 0", t, busy_bad, extra);
            else n_pass++;
        end
    endtask

    task automatic test_fill_check();
        model_op(1'b1, 1'b1, 10'h040, 11'd16, 32'hA5A5_0000);
        run_op(1'b1, 1'b1, 10'h040, 11'd16, 32'hA5A5_0000, 7);
        n_total++;
        if (cap_a.size() !== exp_a.size())
            $display("FAIL fc_count: got %0d want %0d", cap_a.size(), exp_a.size());
        else n_pass++;
        for (int i = 0; i < exp_a.size() && i < cap_a.size(); i++) begin
            n_total++;
            if ({cap_we[i], cap_a[i], cap_d[i]} !== {exp_we[i], exp_a[i], exp_d[i]})
                $display("FAIL fc_access%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h", i,
                         cap_we[i], cap_a[i], cap_d[i], exp_we[i], exp_a[i], exp_d[i]);
            else n_pass++;
        end
        n_total++;
        if ({first_cyc, last_cyc, done_cyc, busy_bad, extra} !== {1, 32, exp_done, 0, 0})
            $display("FAIL fc_timing: got first=%0d last=%0d done=%0d busy_bad=%0d extra=%0d want 1 32 %0d 0 0",
                     first_cyc, last_cyc, done_cyc, busy_bad, extra, exp_done);
        else n_pass++;
        n_total++;
        if ({error, err_count} !== {1'b0, 11'd0})
            $display("FAIL fc_errors: got error=%b cnt=%0d want 0 0", error, err_count);
        else n_pass++;
    endtask

    task automatic test_corrupt();
        for (int t = 0; t < 2; t++) begin
            if (t == 1) poke(10'd5, 32'hDEAD_BEEF);
            model_op(t == 0, t == 1, 10'd0, 11'd8, 32'h0BAD_0000);
            run_op(t == 0, t == 1, 10'd0, 11'd8, 32'h0BAD_0000, 0);
            n_total++;
            if (cap_a.size() !== exp_a.size() || done_cyc !== exp_done)
                $display("FAIL corrupt%0d_shape: got n=%0d done=%0d want n=%0d done=%0d", t,
                         cap_a.size(), done_cyc, exp_a.size(), exp_done);
            else n_pass++;
            n_total++;
            if ({error, err_count, err_addr, err_data} !==
                {exp_cnt != 0, (AW+1)'(exp_cnt), exp_eaddr, exp_edata})
                $display("FAIL corrupt%0d_errors: got err=%b cnt=%0d ea=%h ed=%h want %b %0d %h %h", t,
                         error, err_count, err_addr, err_data, exp_cnt != 0, exp_cnt, exp_eaddr, exp_edata);
            else n_pass++;
        end
    endtask

    task automatic test_zero_len();
        for (int t = 0; t < 2; t++) begin
            model_op(t == 0, t == 0, 10'h123, t == 0 ? 11'd0 : 11'd5, 32'h1);
            run_op(t == 0, t == 0, 10'h123, t == 0 ? 11'd0 : 11'd5, 32'h1, 1);
            n_total++;
            if ({cap_a.size(), first_cyc, done_cyc, busy_bad, extra} !== {0, -1, 2, 0, 0})
                $display("FAIL zero%0d: got n=%0d first=%0d done=%0d busy_bad=%0d extra=%0d want 0 -1 2 0 0",
                         t, cap_a.size(), first_cyc, done_cyc, busy_bad, extra);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic f, c;
        logic [AW-1:0] b;
        logic [AW:0] l;
        logic [31:0] sd;
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 2) == 0) poke(AW'($urandom), $urandom);
            f = 1'($urandom); c = 1'($urandom); b = AW'($urandom);
            l = (AW+1)'($urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, 40));
            sd = $urandom;
            model_op(f, c, b, l, sd);
            run_op(f, c, b, l, sd, $urandom_range(0, exp_done - 1));
            n_total++;
            if (cap_a.size() !== exp_a.size())
                $display("FAIL rnd%0d_count: got %0d want %0d", t, cap_a.size(), exp_a.size());
            else n_pass++;
            for (int i = 0; i < exp_a.size() && i < cap_a.size(); i++) begin
                n_total++;
                if ({cap_we[i], cap_a[i], cap_d[i]} !== {exp_we[i], exp_a[i], exp_d[i]})
                    $display("FAIL rnd%0d_access%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h", t, i,
                             cap_we[i], cap_a[i], cap_d[i], exp_we[i], exp_a[i], exp_d[i]);
                else n_pass++;
            end
            n_total++;
            if ({first_cyc, last_cyc, done_cyc, busy_bad, extra} !==
                {exp_a.size() ? 1 : -1, exp_a.size() ? exp_a.size() : -1, exp_done, 0, 0})
                $display("FAIL rnd%0d_timing: got first=%0d last=%0d done=%0d busy_bad=%0d extra=%0d want n=%0d done=%0d",
                         t, first_cyc, last_cyc, done_cyc, busy_bad, extra, exp_a.size(), exp_done);
            else n_pass++;
            n_total++;
            if ({error, err_count, err_addr, err_data} !==
                {exp_cnt != 0, (AW+1)'(exp_cnt), exp_eaddr, exp_edata})
                $display("FAIL rnd%0d_errors: got err=%b cnt=%0d ea=%h ed=%h want %b %0d %h %h", t,
                         error, err_count, err_addr, err_data, exp_cnt != 0, exp_cnt, exp_eaddr, exp_edata);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_read();
        int quiet = 0;
        for (int i = 0; i < 8; i++) poke(AW'(i), ~(32'h5000 + 32'(i)));
        @(negedge clk);
        start = 1'b1; do_fill = 1'b0; do_check = 1'b1; base_addr = '0; length = 11'd8; seed = 32'h5000;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({mem_chipselect, mem_write, mem_address} !== {1'b1, 1'b0, 10'd2})
            $display("FAIL rst_mid_third_read: got cs=%b we=%b a=%h want 1 0 002", mem_chipselect, mem_write, mem_address);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({mem_chipselect, mem_write, busy, done, error, err_count, err_addr, err_data,
             mem_address, mem_writedata} !== '0)
            $display("FAIL rst_mid_outputs: got cs=%b we=%b busy=%b done=%b err=%b cnt=%0d a=%h wd=%h want all 0",
                     mem_chipselect, mem_write, busy, done, error, err_count, mem_address, mem_writedata);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || mem_chipselect || busy || error || err_count != 0) quiet++;
        end
        n_total++;
        if (quiet !== 0) $display("FAIL rst_mid_after: got %0d active cycles want 0", quiet);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_fill_check();
        test_corrupt();
        test_zero_len();
        test_random();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
